piso_shift_tx: RTL and testbench

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

---
 rtl/piso_pkg.sv | 23 ++
 rtl/piso_bit_cnt.sv | 35 +++
 rtl/piso_shift_tx.sv | 164 ++++++++++++++++
 tb/tb_piso_shift_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared FSM encoding and sizing helper for the piso_shift_tx serializer.
// The PARITY state exists only when PISO_PARITY_EN is defined.
package piso_pkg;

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } piso_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } piso_state_t;
`endif

    // Bit-counter width; never below one bit so the smallest WIDTH still has a register.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit index counter for piso_shift_tx: synchronous clear, enable, and a
// terminal-count flag at WIDTH-1. It saturates there rather than wrapping.
module piso_bit_cnt
    import piso_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          i_clear,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt,
    output logic          o_tc
);

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    assign w_tc = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && !w_tc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter with valid/ready on both sides.
// Optional even-parity bit after each frame when PISO_PARITY_EN is defined.
//
// Handshakes: a transfer happens on a rising edge where valid && ready; a
// source holds its payload stable while valid && !ready; ready never depends
// on the same port's valid.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CW        = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             busy,
    output piso_state_t      o_dbg_state,
    output logic [CW-1:0]    o_dbg_cnt
);

    piso_state_t      r_state;
    logic [WIDTH-1:0] r_shreg;
    logic             r_sout_valid;
    logic             r_busy;
`ifdef PISO_PARITY_EN
    logic             r_par;
`endif

    logic             w_d_ready;
    logic             w_load;
    logic             w_bit_hs;
    logic             w_last_data_hs;
    logic             w_data_bit;
    logic             w_bit;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    w_cnt;
    logic             w_tc;

    assign w_data_bit  = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign w_shreg_nxt = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, r_shreg[WIDTH-1:1]};

    assign w_bit_hs       = r_sout_valid && sout_ready;
    assign w_load         = d_valid && w_d_ready;
    assign w_last_data_hs = (r_state == ST_SHIFT) && w_bit_hs && w_tc;

    // Ready also opens on the final bit of a frame so the next word follows with no gap.
    always_comb begin
        w_d_ready = 1'b0;
        case (r_state)
            ST_IDLE:   w_d_ready = 1'b1;
`ifdef PISO_PARITY_EN
            ST_PARITY: w_d_ready = sout_ready;
`else
            ST_SHIFT:  w_d_ready = w_tc && sout_ready;
`endif
            default:   w_d_ready = 1'b0;
        endcase
    end

    piso_bit_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_cnt (
        .clk     (clk),
        .clr_n   (clr_n),
        .i_clear (w_load || w_last_data_hs),
        .i_en    ((r_state == ST_SHIFT) && w_bit_hs),
        .o_cnt   (w_cnt),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_sout_valid <= 1'b0;
            r_busy       <= 1'b0;
`ifdef PISO_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state      <= ST_SHIFT;
                        r_shreg      <= d;
                        r_sout_valid <= 1'b1;
                        r_busy       <= 1'b1;
`ifdef PISO_PARITY_EN
                        r_par        <= 1'b0;
`endif
                    end
                end

                ST_SHIFT: begin
                    if (w_bit_hs) begin
`ifdef PISO_PARITY_EN
                        r_shreg <= w_shreg_nxt;
                        r_par   <= r_par ^ w_data_bit;
                        if (w_tc) begin
                            r_state <= ST_PARITY;
                        end
`else
                        if (w_tc && w_load) begin
                            r_shreg <= d;
                        end else if (w_tc) begin
                            r_shreg      <= w_shreg_nxt;
                            r_state      <= ST_IDLE;
                            r_sout_valid <= 1'b0;
                            r_busy       <= 1'b0;
                        end else begin
                            r_shreg <= w_shreg_nxt;
                        end
`endif
                    end
                end

`ifdef PISO_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_hs) begin
                        if (w_load) begin
                            r_state <= ST_SHIFT;
                            r_shreg <= d;
                            r_par   <= 1'b0;
                        end else begin
                            r_state      <= ST_IDLE;
                            r_sout_valid <= 1'b0;
                            r_busy       <= 1'b0;
                        end
                    end
                end
`endif

                default: begin
                    r_state      <= ST_IDLE;
                    r_sout_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

`ifdef PISO_PARITY_EN
    assign w_bit = (r_state == ST_PARITY) ? r_par : w_data_bit;
`else
    assign w_bit = w_data_bit;
`endif

    // Gate with valid so sout reads 0 whenever no bit is being offered.
    assign sout        = r_sout_valid & w_bit;
    assign sout_valid  = r_sout_valid;
    assign busy        = r_busy;
    assign d_ready     = w_d_ready;
    assign o_dbg_state = r_state;
    assign o_dbg_cnt   = w_cnt;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed self-checking bench for piso_shift_tx (MSB-first and LSB-first instances).
// Expected frames grow by one parity bit when PISO_PARITY_EN is defined.
module tb_piso_shift_tx;
    import piso_pkg::*;

`ifdef PISO_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic        clk;
    logic        clr_n;
    logic [3:0]  d;
    logic        d_valid;
    logic        d_ready;
    logic        sout;
    logic        sout_valid;
    logic        sout_ready;
    logic        busy;
    piso_state_t dbg_state;
    logic [1:0]  dbg_cnt;

    logic [3:0]  l_d;
    logic        l_d_valid;
    logic        l_d_ready;
    logic        l_sout;
    logic        l_sout_valid;
    logic        l_sout_ready;
    logic        l_busy;
    piso_state_t l_dbg_state;
    logic [1:0]  l_dbg_cnt;

    int total;
    int bad;

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .clr_n(clr_n), .d(d), .d_valid(d_valid), .d_ready(d_ready),
        .sout(sout), .sout_valid(sout_valid), .sout_ready(sout_ready), .busy(busy),
        .o_dbg_state(dbg_state), .o_dbg_cnt(dbg_cnt)
    );

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .clr_n(clr_n), .d(l_d), .d_valid(l_d_valid), .d_ready(l_d_ready),
        .sout(l_sout), .sout_valid(l_sout_valid), .sout_ready(l_sout_ready), .busy(l_busy),
        .o_dbg_state(l_dbg_state), .o_dbg_cnt(l_dbg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit i of an MSB-first frame of word w; index 4 is the even-parity bit.
    function automatic logic exp_msb(input logic [3:0] w, input int i);
        return (i < 4) ? w[3 - i] : ^w;
    endfunction

    function automatic logic exp_lsb(input logic [3:0] w, input int i);
        return (i < 4) ? w[i] : ^w;
    endfunction

    task automatic test_reset();
        clr_n = 1'b0; d = 4'd0; d_valid = 1'b0; sout_ready = 1'b0;
        l_d = 4'd0; l_d_valid = 1'b0; l_sout_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (sout_valid !== 1'b0) begin bad++; $display("FAIL reset_sout_valid got=%0b exp=0", sout_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (sout !== 1'b0) begin bad++; $display("FAIL reset_sout got=%0b exp=0", sout); end
        total++; if (d_ready !== 1'b1) begin bad++; $display("FAIL reset_d_ready got=%0b exp=1", d_ready); end
        total++; if (dbg_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", dbg_cnt); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        // release together with an offered word: the first edge with clr_n high must load it
        clr_n = 1'b1; d = 4'b1011; d_valid = 1'b1; sout_ready = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        total++; if (sout_valid !== 1'b1 || sout !== 1'b1) begin bad++; $display("FAIL first_load valid=%0b sout=%0b exp=1,1", sout_valid, sout); end
        repeat (FL + 1) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL first_load_drain busy=%0b exp=0", busy); end
    endtask

    task automatic test_basic();
        d = 4'b1011; d_valid = 1'b1; sout_ready = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (sout_valid !== 1'b1 || sout !== exp_msb(4'b1011, i)) begin
                bad++; $display("FAIL basic_bit%0d valid=%0b sout=%0b exp=1,%0b", i, sout_valid, sout, exp_msb(4'b1011, i));
            end
        end
        @(negedge clk);
        total++;
        if (sout_valid !== 1'b0 || busy !== 1'b0 || sout !== 1'b0) begin
            bad++; $display("FAIL basic_end valid=%0b busy=%0b sout=%0b exp=0,0,0", sout_valid, busy, sout);
        end
    endtask

    task automatic test_stall();
        logic [3:0] w;
        w = 4'b1011;
        d = w; d_valid = 1'b1; sout_ready = 1'b1;
        @(negedge clk);
        d_valid = 1'b0; sout_ready = 1'b0;
        total++; if (sout !== 1'b1 || dbg_cnt !== 2'd0) begin bad++; $display("FAIL stall_bit0 sout=%0b cnt=%0d exp=1,0", sout, dbg_cnt); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (sout_valid !== 1'b1 || sout !== 1'b1 || dbg_cnt !== 2'd0) begin
                bad++; $display("FAIL stall_hold%0d valid=%0b sout=%0b cnt=%0d exp=1,1,0", k, sout_valid, sout, dbg_cnt);
            end
        end
        sout_ready = 1'b1;
        for (int i = 1; i < FL; i++) begin
            @(negedge clk);
            total++;
            if (sout_valid !== 1'b1 || sout !== exp_msb(w, i)) begin
                bad++; $display("FAIL stall_resume%0d valid=%0b sout=%0b exp=1,%0b", i, sout_valid, sout, exp_msb(w, i));
            end
            if (i < 4) begin
                total++;
                if (dbg_cnt !== 2'(i)) begin bad++; $display("FAIL stall_cnt%0d got=%0d exp=%0d", i, dbg_cnt, i); end
            end
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_end busy=%0b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w0;
        logic [3:0] w1;
        logic       e;
        w0 = 4'b1011; w1 = 4'b0110;
        d = w0; d_valid = 1'b1; sout_ready = 1'b1;
        for (int i = 0; i < 2 * FL; i++) begin
            @(negedge clk);
            if (i == 0) d = w1;
            e = (i < FL) ? exp_msb(w0, i) : exp_msb(w1, i - FL);
            total++;
            if (sout_valid !== 1'b1 || sout !== e) begin
                bad++; $display("FAIL b2b_bit%0d valid=%0b sout=%0b exp=1,%0b", i, sout_valid, sout, e);
            end
            if (i == FL - 1) begin
                total++;
                if (d_ready !== 1'b1) begin bad++; $display("FAIL b2b_gapless_ready got=%0b exp=1", d_ready); end
            end
            if (i == FL) d_valid = 1'b0;
        end
        @(negedge clk);
        total++; if (sout_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_end valid=%0b busy=%0b exp=0,0", sout_valid, busy); end
    endtask

    task automatic test_ignore();
        logic [3:0] w;
        w = 4'b0001;
        d = w; d_valid = 1'b1; sout_ready = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (sout_valid !== 1'b1 || sout !== exp_msb(w, i)) begin
                bad++; $display("FAIL ignore_bit%0d valid=%0b sout=%0b exp=1,%0b", i, sout_valid, sout, exp_msb(w, i));
            end
            if (i == 0) begin
                total++;
                if (d_ready !== 1'b0) begin bad++; $display("FAIL ignore_ready got=%0b exp=0", d_ready); end
                d = 4'b1111; d_valid = 1'b1;
            end
            if (i == 1) d_valid = 1'b0;
        end
        @(negedge clk);
        total++; if (busy !== 1'b0 || sout_valid !== 1'b0) begin bad++; $display("FAIL ignore_end busy=%0b valid=%0b exp=0,0", busy, sout_valid); end
    endtask

    task automatic test_reset_mid();
        d = 4'b1011; d_valid = 1'b1; sout_ready = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        total++; if (sout !== 1'b1) begin bad++; $display("FAIL mid_bit0 got=%0b exp=1", sout); end
        @(negedge clk);
        total++; if (sout !== 1'b0) begin bad++; $display("FAIL mid_bit1 got=%0b exp=0", sout); end
        @(negedge clk);
        #2 clr_n = 1'b0;
        #1;
        total++;
        if (sout_valid !== 1'b0 || busy !== 1'b0 || sout !== 1'b0 || dbg_cnt !== 2'd0) begin
            bad++; $display("FAIL mid_async valid=%0b busy=%0b sout=%0b cnt=%0d exp=0,0,0,0", sout_valid, busy, sout, dbg_cnt);
        end
        @(negedge clk);
        clr_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if (sout_valid !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL mid_after%0d valid=%0b busy=%0b exp=0,0", k, sout_valid, busy);
            end
        end
    endtask

    task automatic test_lsb();
        logic [3:0] w;
        w = 4'b1011;
        l_d = w; l_d_valid = 1'b1; l_sout_ready = 1'b1;
        @(negedge clk);
        l_d_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (l_sout_valid !== 1'b1 || l_sout !== exp_lsb(w, i)) begin
                bad++; $display("FAIL lsb_bit%0d valid=%0b sout=%0b exp=1,%0b", i, l_sout_valid, l_sout, exp_lsb(w, i));
            end
        end
        @(negedge clk);
        total++; if (l_sout_valid !== 1'b0 || l_busy !== 1'b0) begin bad++; $display("FAIL lsb_end valid=%0b busy=%0b exp=0,0", l_sout_valid, l_busy); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_lsb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
